// File: rtl/mdu_pkg.sv
// Shared types and helpers for the multicycle multiply/divide unit.
// Build option: MDU_HILO_WRITE_EN adds mthi/mtlo write ports on the top.
package mdu_pkg;

    // Default operand width of the core datapath.
    localparam int MDU_WIDTH = 32;
    // Iteration counter width for the default operand width.
    localparam int CNT_W     = $clog2(MDU_WIDTH);

    typedef enum logic [1:0] {
        MULT  = 2'd0,
        MULTU = 2'd1,
        DIV   = 2'd2,
        DIVU  = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Magnitude of a default-width operand; unsigned operands pass through.
    function automatic logic [MDU_WIDTH-1:0] abs_w(input logic [MDU_WIDTH-1:0] v,
                                                   input logic                 is_signed);
        return (is_signed && v[MDU_WIDTH-1]) ? -v : v;
    endfunction

endpackage

// File: rtl/mdu_iter_step.sv
// One iteration of the multicycle datapath, purely combinational.
// Multiply: radix-2 shift-add, accumulator = {partial product, multiplier}.
// Divide: restoring shift-subtract, accumulator = {remainder, dividend/quotient}.
module mdu_iter_step #(
    parameter int WIDTH = 32
) (
    input  logic                 i_is_div,
    input  logic [2*WIDTH-1:0]   i_acc,
    input  logic [WIDTH-1:0]     i_opnd,
    output logic [2*WIDTH-1:0]   o_acc
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_rem_sh;
    logic [WIDTH:0] w_diff;

    // Compute both candidate updates and select by op class.
    always_comb begin
        // Add multiplicand into the upper half when the current multiplier bit is set;
        // keep the carry so the right shift brings it back in.
        w_sum    = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_opnd} : {(WIDTH+1){1'b0}});
        // Remainder shifted left with the next dividend bit; needs WIDTH+1 bits.
        w_rem_sh = i_acc[2*WIDTH-1:WIDTH-1];
        // MSB of the difference is the borrow: set when remainder < divisor.
        w_diff   = w_rem_sh - {1'b0, i_opnd};
        o_acc    = {w_sum, i_acc[WIDTH-1:1]};
        if (i_is_div) begin
            if (!w_diff[WIDTH]) begin
                o_acc = {w_diff[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b1};
            end else begin
                o_acc = {w_rem_sh[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle multiply/divide unit with HI/LO result registers.
// Signed ops run on magnitudes and are sign-corrected in a FIX cycle.
// Build option: MDU_HILO_WRITE_EN adds i_hi_wr/i_lo_wr/i_wr_data (mthi/mtlo).
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             i_clock,
    input  logic             i_res,
    input  logic             i_start,
    input  op_t              i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_div_zero,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
`ifdef MDU_HILO_WRITE_EN
    ,
    input  logic             i_hi_wr,
    input  logic             i_lo_wr,
    input  logic [WIDTH-1:0] i_wr_data
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_IT = CW'(WIDTH - 1);

    state_t               r_state;
    state_t               w_next;
    logic [CW-1:0]        r_cnt;
    op_t                  r_op;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_opnd;
    logic                 r_neg_lo;   // negate product / quotient
    logic                 r_neg_hi;   // negate remainder (dividend was negative)
    logic                 r_dz;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;

    logic                 w_in_div;
    logic                 w_in_signed;
    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic                 w_b_zero;
    logic                 w_r_div;
    logic [2*WIDTH-1:0]   w_step;
    logic [2*WIDTH-1:0]   w_prod_fix;
    logic [WIDTH-1:0]     w_quo_fix;
    logic [WIDTH-1:0]     w_rem_fix;

    // Decode the incoming request and form operand magnitudes.
    always_comb begin
        w_in_div    = (i_op == DIV) || (i_op == DIVU);
        w_in_signed = (i_op == MULT) || (i_op == DIV);
        w_a_neg     = w_in_signed & i_a[WIDTH-1];
        w_b_neg     = w_in_signed & i_b[WIDTH-1];
        w_a_mag     = w_a_neg ? -i_a : i_a;
        w_b_mag     = w_b_neg ? -i_b : i_b;
        w_b_zero    = (i_b == '0);
    end

    // Sign correction applied to the finished magnitude result.
    always_comb begin
        w_r_div    = (r_op == DIV) || (r_op == DIVU);
        w_prod_fix = r_neg_lo ? -r_acc : r_acc;
        w_quo_fix  = r_neg_lo ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
        w_rem_fix  = r_neg_hi ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    end

    mdu_iter_step #(.WIDTH(WIDTH)) u_step (
        .i_is_div (w_r_div),
        .i_acc    (r_acc),
        .i_opnd   (r_opnd),
        .o_acc    (w_step)
    );

    // State register.
    always_ff @(posedge i_clock or negedge i_res) begin
        if (!i_res) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; divide by zero skips straight to DONE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_next = (w_in_div && w_b_zero) ? DONE : RUN;
                end
            end
            RUN:     if (r_cnt == LAST_IT) w_next = FIX;
            FIX:     w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Datapath: latch request, iterate, then load HI/LO at the end of FIX.
    always_ff @(posedge i_clock or negedge i_res) begin
        if (!i_res) begin
            r_cnt    <= '0;
            r_op     <= MULT;
            r_acc    <= '0;
            r_opnd   <= '0;
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
            r_dz     <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_op     <= i_op;
                        r_cnt    <= '0;
                        r_acc    <= w_in_div ? {{WIDTH{1'b0}}, w_a_mag} : {{WIDTH{1'b0}}, w_b_mag};
                        r_opnd   <= w_in_div ? w_b_mag : w_a_mag;
                        r_neg_lo <= w_a_neg ^ w_b_neg;
                        r_neg_hi <= w_in_div & w_a_neg;
                        r_dz     <= w_in_div & w_b_zero;
                    end
                end
                RUN: begin
                    r_acc <= w_step;
                    r_cnt <= (r_cnt == LAST_IT) ? '0 : r_cnt + CW'(1);
                end
                FIX: begin
                    if (w_r_div) begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quo_fix;
                    end else begin
                        r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
`ifdef MDU_HILO_WRITE_EN
            // mthi/mtlo only take effect while idle.
            if (r_state == IDLE) begin
                if (i_hi_wr) r_hi <= i_wr_data;
                if (i_lo_wr) r_lo <= i_wr_data;
            end
`endif
        end
    end

    assign o_busy     = (r_state == RUN) || (r_state == FIX);
    assign o_done     = (r_state == DONE);
    assign o_div_zero = (r_state == DONE) && r_dz;
    assign o_hi       = r_hi;
    assign o_lo       = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit (default build, WIDTH=32).
module tb_mult_div_unit;
    import mdu_pkg::*;

    localparam int W = 32;

    logic         i_clock = 1'b0;
    logic         i_res   = 1'b0;
    logic         i_start = 1'b0;
    op_t          i_op    = MULT;
    logic [W-1:0] i_a     = '0;
    logic [W-1:0] i_b     = '0;
    logic         o_busy;
    logic         o_done;
    logic         o_div_zero;
    logic [W-1:0] o_hi;
    logic [W-1:0] o_lo;
`ifdef MDU_HILO_WRITE_EN
    logic         i_hi_wr   = 1'b0;
    logic         i_lo_wr   = 1'b0;
    logic [W-1:0] i_wr_data = '0;
`endif

    int checks = 0;
    int errors = 0;

    mult_div_unit #(.WIDTH(W)) dut (
        .i_clock    (i_clock),
        .i_res      (i_res),
        .i_start    (i_start),
        .i_op       (i_op),
        .i_a        (i_a),
        .i_b        (i_b),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_div_zero (o_div_zero),
        .o_hi       (o_hi),
        .o_lo       (o_lo)
`ifdef MDU_HILO_WRITE_EN
        ,
        .i_hi_wr    (i_hi_wr),
        .i_lo_wr    (i_lo_wr),
        .i_wr_data  (i_wr_data)
`endif
    );

    always #5 i_clock = ~i_clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    // Issue one op; return latency in cycles after acceptance, busy one cycle
    // after acceptance, and busy/div_zero seen in the done cycle (or at timeout).
    task automatic run_op(input op_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output logic busy1, output logic busy_d,
                          output logic dz);
        i_op = op; i_a = a; i_b = b; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        i_a = '1; i_b = '1; i_op = DIVU;   // later input changes must not matter
        lat   = 1;
        busy1 = o_busy;
        while (!o_done && lat < 200) begin
            tick();
            lat++;
        end
        busy_d = o_busy;
        dz     = o_div_zero;
    endtask

    int   lat;
    logic b1, bd, dz, seen_done;

    initial begin
        // Reset state
        #2;
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_dz",   o_div_zero, 0);
        chk("rst_hi",   o_hi, 0);
        chk("rst_lo",   o_lo, 0);
        tick(); tick();
        i_res = 1'b1;
        tick();

        // MULT -1 * 2
        run_op(MULT, 32'hFFFF_FFFF, 32'h0000_0002, lat, b1, bd, dz);
        chk("mult_lat",   lat, 34);
        chk("mult_busy1", b1, 1);
        chk("mult_busyd", bd, 0);
        chk("mult_dz",    dz, 0);
        chk("mult_hi",    o_hi, 32'hFFFF_FFFF);
        chk("mult_lo",    o_lo, 32'hFFFF_FFFE);
        tick();
        chk("mult_idle_done", o_done, 0);

        // MULTU same operands
        run_op(MULTU, 32'hFFFF_FFFF, 32'h0000_0002, lat, b1, bd, dz);
        chk("multu_lat", lat, 34);
        chk("multu_hi",  o_hi, 32'h0000_0001);
        chk("multu_lo",  o_lo, 32'hFFFF_FFFE);
        tick();

        // MULTU max * max
        run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, b1, bd, dz);
        chk("multu_max_hi", o_hi, 32'hFFFF_FFFE);
        chk("multu_max_lo", o_lo, 32'h0000_0001);
        tick();

        // MULT -3 * -5
        run_op(MULT, 32'hFFFF_FFFD, 32'hFFFF_FFFB, lat, b1, bd, dz);
        chk("mult_nn_hi", o_hi, 32'h0000_0000);
        chk("mult_nn_lo", o_lo, 32'h0000_000F);
        tick();

        // DIV -7 / 2
        run_op(DIV, 32'hFFFF_FFF9, 32'h0000_0002, lat, b1, bd, dz);
        chk("div_lat", lat, 34);
        chk("div_lo",  o_lo, 32'hFFFF_FFFD);
        chk("div_hi",  o_hi, 32'hFFFF_FFFF);
        tick();

        // DIV 7 / -2
        run_op(DIV, 32'h0000_0007, 32'hFFFF_FFFE, lat, b1, bd, dz);
        chk("div_pn_lo", o_lo, 32'hFFFF_FFFD);
        chk("div_pn_hi", o_hi, 32'h0000_0001);
        tick();

        // DIVU 100 / 7
        run_op(DIVU, 32'd100, 32'd7, lat, b1, bd, dz);
        chk("divu_lo", o_lo, 32'd14);
        chk("divu_hi", o_hi, 32'd2);
        chk("divu_dz", dz, 0);
        tick();

        // DIVU by zero: immediate done, HI/LO kept
        run_op(DIVU, 32'd55, 32'd0, lat, b1, bd, dz);
        chk("dz_lat",   lat, 1);
        chk("dz_busy1", b1, 0);
        chk("dz_flag",  dz, 1);
        chk("dz_hi",    o_hi, 32'd2);
        chk("dz_lo",    o_lo, 32'd14);
        tick();
        chk("dz_flag_clr", o_div_zero, 0);

        // DIV MIN / -1
        run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, b1, bd, dz);
        chk("ovf_lo", o_lo, 32'h8000_0000);
        chk("ovf_hi", o_hi, 32'h0000_0000);
        chk("ovf_dz", dz, 0);
        tick();

        // Second start during a MULT is ignored
        i_op = MULT; i_a = 32'd3; i_b = 32'd4; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        lat = 1;
        repeat (8) begin tick(); lat++; end
        i_op = DIVU; i_a = 32'd100; i_b = 32'd7; i_start = 1'b1;
        tick(); lat++;
        i_start = 1'b0;
        while (!o_done && lat < 200) begin tick(); lat++; end
        chk("ign_lat", lat, 34);
        chk("ign_hi",  o_hi, 32'd0);
        chk("ign_lo",  o_lo, 32'd12);
        tick();
        chk("ign_idle_busy", o_busy, 0);

        // Reset mid-DIV aborts with no done
        i_op = DIV; i_a = 32'd100; i_b = 32'd7; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        repeat (13) tick();
        chk("pre_rst_busy", o_busy, 1);
        #3;
        i_res = 1'b0;
        #1;
        chk("abort_busy", o_busy, 0);
        chk("abort_done", o_done, 0);
        chk("abort_hi",   o_hi, 0);
        chk("abort_lo",   o_lo, 0);
        seen_done = 1'b0;
        repeat (3) begin tick(); seen_done |= o_done; end
        i_res = 1'b1;
        repeat (40) begin tick(); seen_done |= o_done | o_busy; end
        chk("abort_no_done", seen_done, 0);

        // Fresh MULTU after abort
        run_op(MULTU, 32'd3, 32'd5, lat, b1, bd, dz);
        chk("post_lat", lat, 34);
        chk("post_lo",  o_lo, 32'd15);
        chk("post_hi",  o_hi, 32'd0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
